// File: rtl/organization_unit.sv
// organization_unit: pipeline entry stage that registers one
// execution event per clock from scheduler, thread image and read return.

package EV_types;

    localparam int NUM_WORDS = 16;
    localparam int ID_W      = 4;

    typedef logic [ID_W-1:0] thread_id_t;

    typedef union packed {
        logic [NUM_WORDS-1:0][31:0] u32;
        logic [NUM_WORDS*32-1:0]    bits;
    } thread_register_union_t;

    typedef union packed {
        logic [NUM_WORDS-1:0][31:0] u32;
        logic [NUM_WORDS*32-1:0]    bits;
    } data_union_t;

    typedef struct packed {
        logic       active_thread;
        thread_id_t id;
        logic       halt;
        logic [7:0] flags;
    } system_t;

    typedef struct packed {
        thread_register_union_t thread;
        data_union_t            data;
        system_t                system;
        logic [31:0]            scratch;
    } pipeline_pass_structure;

endpackage

package DataInterface_pkg;

    import EV_types::*;

    typedef struct packed {
        data_union_t data;
        logic        valid;
        thread_id_t  receive_id;
    } read_return_t;

endpackage

module organization_unit
    import EV_types::*;
    import DataInterface_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   active,
    input  thread_register_union_t thread,
    input  thread_id_t             thread_id,
    input  read_return_t           data_return,
    output pipeline_pass_structure execution_ev
);

    pipeline_pass_structure next_ev;
    logic                   data_hit;

    // a read return is only forwarded to the thread that issued it
    always_comb begin
        data_hit = data_return.valid
                 && (data_return.receive_id == thread_id);
    end

    // assemble the next event; bubble (all zero) when no thread is active
    always_comb begin
        next_ev = '0;
        if (active) begin
            next_ev.thread               = thread;
            next_ev.system.active_thread = 1'b1;
            next_ev.system.id            = thread_id;
            if (data_hit) begin
                next_ev.data = data_return.data;
            end
        end
    end

    // single output register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            execution_ev <= '0;
        end else begin
            execution_ev <= next_ev;
        end
    end

endmodule

// File: tb/tb_organization_unit.sv
// tb_organization_unit: directed checks of capture, bubble,
// data-match rule, latency and asynchronous reset.

module tb_organization_unit;

    import EV_types::*;
    import DataInterface_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   active;
    thread_register_union_t thread;
    thread_id_t             thread_id;
    read_return_t           data_return;
    pipeline_pass_structure execution_ev;

    pipeline_pass_structure zero_ev;

    int tests;
    int fails;

    organization_unit dut (
        .clk          (clk),
        .rst          (rst),
        .active       (active),
        .thread       (thread),
        .thread_id    (thread_id),
        .data_return  (data_return),
        .execution_ev (execution_ev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scenario2();
        active                   = 1'b1;
        thread_id                = 4'd0;
        thread                   = '0;
        thread.u32[10]           = 32'd35;
        data_return              = '0;
        data_return.data.u32[10] = 32'd6;
        data_return.valid        = 1'b1;
        data_return.receive_id   = 4'd0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        active      = 1'b0;
        thread      = '0;
        thread_id   = '0;
        data_return = '0;
        step();
        tests++;
        if (execution_ev !== zero_ev) begin
            fails++;
            $display("FAIL reset_ev: got %0d set bits, want 0",
                     $countones(execution_ev));
        end
        tests++;
        if (execution_ev.system.active_thread !== 1'b0) begin
            fails++;
            $display("FAIL reset_active: got %b want 0",
                     execution_ev.system.active_thread);
        end
    endtask

    task automatic test_active_capture();
        rst = 1'b1;
        step();
        set_scenario2();
        step();
        tests++;
        if (execution_ev.data.u32[10] !== 32'd6) begin
            fails++;
            $display("FAIL cap_data: got %0d want 6",
                     execution_ev.data.u32[10]);
        end
        tests++;
        if (execution_ev.thread.u32[10] !== 32'd35) begin
            fails++;
            $display("FAIL cap_thread: got %0d want 35",
                     execution_ev.thread.u32[10]);
        end
        tests++;
        if (execution_ev.system.active_thread !== 1'b1) begin
            fails++;
            $display("FAIL cap_active: got %b want 1",
                     execution_ev.system.active_thread);
        end
        tests++;
        if (execution_ev.system.id !== 4'd0) begin
            fails++;
            $display("FAIL cap_id: got %0d want 0",
                     execution_ev.system.id);
        end
        tests++;
        if (execution_ev.scratch !== 32'd0
            || execution_ev.system.flags !== 8'd0
            || execution_ev.system.halt !== 1'b0) begin
            fails++;
            $display("FAIL cap_other: scratch %0h flags %0h halt %b want 0",
                     execution_ev.scratch, execution_ev.system.flags,
                     execution_ev.system.halt);
        end
    endtask

    task automatic test_bubble();
        set_scenario2();
        active = 1'b0;
        step();
        tests++;
        if (execution_ev !== zero_ev) begin
            fails++;
            $display("FAIL bubble_ev: got %0d set bits, want 0",
                     $countones(execution_ev));
        end
    endtask

    task automatic test_id_forwarding();
        set_scenario2();
        thread_id              = 4'd15;
        data_return.receive_id = 4'd15;
        step();
        tests++;
        if (execution_ev.system.id !== 4'd15) begin
            fails++;
            $display("FAIL fwd_id: got %0d want 15",
                     execution_ev.system.id);
        end
        tests++;
        if (execution_ev.data.u32[10] !== 32'd6) begin
            fails++;
            $display("FAIL fwd_data: got %0d want 6",
                     execution_ev.data.u32[10]);
        end
        tests++;
        if (execution_ev.thread.u32[10] !== 32'd35) begin
            fails++;
            $display("FAIL fwd_thread: got %0d want 35",
                     execution_ev.thread.u32[10]);
        end
        tests++;
        if (execution_ev.system.active_thread !== 1'b1) begin
            fails++;
            $display("FAIL fwd_active: got %b want 1",
                     execution_ev.system.active_thread);
        end
    endtask

    task automatic test_mismatch();
        set_scenario2();
        thread_id              = 4'd15;
        data_return.receive_id = 4'd3;
        step();
        tests++;
        if (execution_ev.data !== '0) begin
            fails++;
            $display("FAIL mis_data: got word10 %0d, %0d set bits, want 0",
                     execution_ev.data.u32[10],
                     $countones(execution_ev.data));
        end
        tests++;
        if (execution_ev.thread.u32[10] !== 32'd35) begin
            fails++;
            $display("FAIL mis_thread: got %0d want 35",
                     execution_ev.thread.u32[10]);
        end
        data_return.receive_id = 4'd15;
        data_return.valid      = 1'b0;
        step();
        tests++;
        if (execution_ev.data !== '0) begin
            fails++;
            $display("FAIL inv_data: got word10 %0d, %0d set bits, want 0",
                     execution_ev.data.u32[10],
                     $countones(execution_ev.data));
        end
        tests++;
        if (execution_ev.system.id !== 4'd15) begin
            fails++;
            $display("FAIL inv_id: got %0d want 15",
                     execution_ev.system.id);
        end
    endtask

    task automatic test_back_to_back();
        set_scenario2();
        for (int i = 0; i < 4; i++) begin
            thread_id                = 4'(i + 1);
            thread.u32[0]            = 32'(100 + i);
            data_return.receive_id   = 4'(i + 1);
            data_return.data.u32[0]  = 32'(200 + i);
            data_return.valid        = (i != 2);
            step();
            tests++;
            if (execution_ev.system.id !== 4'(i + 1)
                || execution_ev.thread.u32[0] !== 32'(100 + i)
                || execution_ev.data.u32[0]
                   !== ((i != 2) ? 32'(200 + i) : 32'd0)) begin
                fails++;
                $display("FAIL b2b_%0d: id %0d thr %0d data %0d",
                         i, execution_ev.system.id,
                         execution_ev.thread.u32[0],
                         execution_ev.data.u32[0]);
            end
        end
        // inputs changing between edges must not reach the output
        thread.u32[0] = 32'd999;
        thread_id     = 4'd9;
        active        = 1'b0;
        #2;
        tests++;
        if (execution_ev.thread.u32[0] !== 32'd103
            || execution_ev.system.id !== 4'd4
            || execution_ev.system.active_thread !== 1'b1) begin
            fails++;
            $display("FAIL hold: thr %0d id %0d act %b want 103 4 1",
                     execution_ev.thread.u32[0],
                     execution_ev.system.id,
                     execution_ev.system.active_thread);
        end
        step();
        active = 1'b1;
        step();
        tests++;
        if (execution_ev.thread.u32[0] !== 32'd999
            || execution_ev.system.id !== 4'd9
            || execution_ev.system.active_thread !== 1'b1) begin
            fails++;
            $display("FAIL reenter: thr %0d id %0d act %b want 999 9 1",
                     execution_ev.thread.u32[0],
                     execution_ev.system.id,
                     execution_ev.system.active_thread);
        end
    endtask

    task automatic test_async_reset();
        set_scenario2();
        thread_id              = 4'd15;
        data_return.receive_id = 4'd15;
        step();
        tests++;
        if (execution_ev.system.active_thread !== 1'b1) begin
            fails++;
            $display("FAIL ar_pre: got %b want 1",
                     execution_ev.system.active_thread);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (execution_ev !== zero_ev) begin
            fails++;
            $display("FAIL ar_now: got %0d set bits, want 0",
                     $countones(execution_ev));
        end
        step();
        tests++;
        if (execution_ev !== zero_ev) begin
            fails++;
            $display("FAIL ar_hold: got %0d set bits, want 0",
                     $countones(execution_ev));
        end
        rst = 1'b1;
        step();
        tests++;
        if (execution_ev.system.id !== 4'd15
            || execution_ev.data.u32[10] !== 32'd6) begin
            fails++;
            $display("FAIL ar_resume: id %0d data %0d want 15 6",
                     execution_ev.system.id,
                     execution_ev.data.u32[10]);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        zero_ev = '0;
        test_reset();
        test_active_capture();
        test_bubble();
        test_id_forwarding();
        test_mismatch();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
